// File: rtl/ramulator_req_tracker_if.sv
// Client, wrapper and response-side signals of ramulator_req_tracker.
// The slave modport is the tracker's view; master is the environment's view.
interface ramulator_req_tracker_if #(
  parameter int NUM_ENTRIES = 8,
  parameter int ADDR_W      = 64,
  parameter int SRC_W       = 32
);
  localparam int CNT_W = $clog2(NUM_ENTRIES) + 1;

  logic              in_req_valid;
  logic              in_req_ready;
  logic [ADDR_W-1:0] in_req_addr;
  logic              in_req_type;
  logic [SRC_W-1:0]  in_req_source_id;

  logic              mem_init_done;
  logic              mem_req_valid;
  logic [63:0]       mem_req_addr;
  logic              mem_req_type;
  logic [31:0]       mem_req_source_id;
  logic              mem_req_ready;
  logic              mem_resp_valid;
  logic [63:0]       mem_resp_addr;

  logic              out_rsp_valid;
  logic              out_rsp_ready;
  logic [ADDR_W-1:0] out_rsp_addr;
  logic [SRC_W-1:0]  out_rsp_source_id;

  logic [CNT_W-1:0]  outstanding;
  logic              err_unmatched;

  modport slave (
    input  in_req_valid, in_req_addr, in_req_type, in_req_source_id,
    input  mem_init_done, mem_req_ready, mem_resp_valid, mem_resp_addr,
    input  out_rsp_ready,
    output in_req_ready, mem_req_valid, mem_req_addr, mem_req_type, mem_req_source_id,
    output out_rsp_valid, out_rsp_addr, out_rsp_source_id, outstanding, err_unmatched
  );

  modport master (
    output in_req_valid, in_req_addr, in_req_type, in_req_source_id,
    output mem_init_done, mem_req_ready, mem_resp_valid, mem_resp_addr,
    output out_rsp_ready,
    input  in_req_ready, mem_req_valid, mem_req_addr, mem_req_type, mem_req_source_id,
    input  out_rsp_valid, out_rsp_addr, out_rsp_source_id, outstanding, err_unmatched
  );
endinterface

// File: rtl/ramulator_req_tracker.sv
// Serialises client requests into the Ramulator wrapper's pulse/ack protocol,
// retries rejected requests and tags address-only read responses with source_id.
module ramulator_req_tracker #(
  parameter int NUM_ENTRIES = 8,
  parameter int ADDR_W      = 64,
  parameter int SRC_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ramulator_req_tracker_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = IDX_W + 1;

  // state   | meaning
  // S_IDLE  | accepting a new client request
  // S_ISSUE | one-cycle mem_req_valid pulse of the captured request
  // S_WAIT  | sampling the wrapper's registered ack; retry on reject
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;
  typedef enum logic [1:0] {E_FREE, E_PENDING, E_OUTST, E_RETURNED} entry_e;

  state_e            r_state;
  logic              r_mem_req_valid;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_req_type;
  logic [SRC_W-1:0]  r_req_src;
  logic [IDX_W-1:0]  r_req_idx;

  entry_e            r_ent_st   [NUM_ENTRIES];
  logic [ADDR_W-1:0] r_ent_addr [NUM_ENTRIES];
  logic [SRC_W-1:0]  r_ent_src  [NUM_ENTRIES];

  logic [IDX_W-1:0]  r_fifo [NUM_ENTRIES];
  logic [CNT_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_outstanding;
  logic              r_err_unmatched;

  logic              w_dup;
  logic              w_free_any;
  logic [IDX_W-1:0]  w_free_idx;
  logic              w_hit;
  logic [IDX_W-1:0]  w_hit_idx;
  logic [IDX_W-1:0]  w_head_idx;
  logic              w_req_ready;
  logic              w_accept;
  logic              w_alloc;
  logic              w_ack;
  logic              w_match;
  logic              w_miss;
  logic              w_rsp_valid;
  logic              w_pop;

  // Lowest free index wins, hence the descending scan.
  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (r_ent_st[i] == E_FREE) begin
        w_free_any = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_dup     = 1'b0;
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (r_ent_st[i] != E_FREE && r_ent_addr[i] == bus.in_req_addr)
        w_dup = 1'b1;
      if (r_ent_st[i] == E_OUTST && 64'(r_ent_addr[i]) == bus.mem_resp_addr) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  assign w_req_ready = (r_state == S_IDLE) && bus.mem_init_done && !w_dup &&
                       (bus.in_req_type || w_free_any);
  assign w_accept    = bus.in_req_valid && w_req_ready;
  assign w_alloc     = w_accept && !bus.in_req_type;
  assign w_ack       = (r_state == S_WAIT) && bus.mem_req_ready && !r_req_type;
  assign w_match     = bus.mem_resp_valid && w_hit;
  assign w_miss      = bus.mem_resp_valid && !w_hit;
  assign w_rsp_valid = (r_wr_ptr != r_rd_ptr);
  assign w_head_idx  = r_fifo[r_rd_ptr[IDX_W-1:0]];
  assign w_pop       = w_rsp_valid && bus.out_rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_mem_req_valid <= 1'b0;
      r_req_addr      <= '0;
      r_req_type      <= 1'b0;
      r_req_src       <= '0;
      r_req_idx       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_mem_req_valid <= 1'b0;
          if (w_accept) begin
            r_req_addr      <= bus.in_req_addr;
            r_req_type      <= bus.in_req_type;
            r_req_src       <= bus.in_req_source_id;
            r_req_idx       <= w_free_idx;
            r_mem_req_valid <= 1'b1;
            r_state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_mem_req_valid <= 1'b0;
          r_state         <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= S_IDLE;
          end else begin
            r_mem_req_valid <= 1'b1;
            r_state         <= S_ISSUE;
          end
        end
        default: begin
          r_mem_req_valid <= 1'b0;
          r_state         <= S_IDLE;
        end
      endcase
    end
  end

  // Each event targets an entry in a different state, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_ent_st[i]   <= E_FREE;
        r_ent_addr[i] <= '0;
        r_ent_src[i]  <= '0;
      end
    end else begin
      if (w_alloc) begin
        r_ent_st[w_free_idx]   <= E_PENDING;
        r_ent_addr[w_free_idx] <= bus.in_req_addr;
        r_ent_src[w_free_idx]  <= bus.in_req_source_id;
      end
      if (w_ack)
        r_ent_st[r_req_idx] <= E_OUTST;
      if (w_match)
        r_ent_st[w_hit_idx] <= E_RETURNED;
      if (w_pop)
        r_ent_st[w_head_idx] <= E_FREE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++)
        r_fifo[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_match) begin
        r_fifo[r_wr_ptr[IDX_W-1:0]] <= w_hit_idx;
        r_wr_ptr                    <= r_wr_ptr + CNT_W'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding   <= '0;
      r_err_unmatched <= 1'b0;
    end else begin
      case ({w_alloc, w_pop})
        2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      if (w_miss)
        r_err_unmatched <= 1'b1;
    end
  end

  assign bus.in_req_ready      = w_req_ready;
  assign bus.mem_req_valid     = r_mem_req_valid;
  assign bus.mem_req_addr      = 64'(r_req_addr);
  assign bus.mem_req_type      = r_req_type;
  assign bus.mem_req_source_id = 32'(r_req_src);
  assign bus.out_rsp_valid     = w_rsp_valid;
  assign bus.out_rsp_addr      = w_rsp_valid ? r_ent_addr[w_head_idx] : '0;
  assign bus.out_rsp_source_id = w_rsp_valid ? r_ent_src[w_head_idx] : '0;
  assign bus.outstanding       = r_outstanding;
  assign bus.err_unmatched     = r_err_unmatched;
endmodule

// File: tb/tb_ramulator_req_tracker.sv
// Directed bench for ramulator_req_tracker: table-driven request/response
// vectors plus hand-written sequences for stalls, ordering and reset.
module tb_ramulator_req_tracker;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  ramulator_req_tracker_if #(.NUM_ENTRIES(8), .ADDR_W(64), .SRC_W(32)) bus ();

  ramulator_req_tracker #(.NUM_ENTRIES(8), .ADDR_W(64), .SRC_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        t;
    logic [63:0] addr;
    logic [31:0] src;
    int          nrej;
    int          exp_pulses;
    int          exp_outst;
  } req_vec_t;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] exp_src;
    int          exp_outst;
  } rsp_vec_t;

  req_vec_t rv [4];
  rsp_vec_t sv [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers a request, waits for acceptance, then plays the wrapper:
  // rejects nrej times, then acks. Counts correct pulses and stray pulses.
  task automatic send_req(input logic t, input logic [63:0] a, input logic [31:0] s,
                          input int nrej, output int pulses, output int stray, output bit ok);
    int waited = 0;
    pulses = 0;
    stray  = 0;
    bus.in_req_valid     = 1'b1;
    bus.in_req_type      = t;
    bus.in_req_addr      = a;
    bus.in_req_source_id = s;
    #1;
    while (!bus.in_req_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!bus.in_req_ready) begin
      ok = 1'b0;
      bus.in_req_valid = 1'b0;
      return;
    end
    ok = 1'b1;
    tick();
    bus.in_req_valid = 1'b0;
    for (int r = 0; r <= nrej; r++) begin
      if (bus.mem_req_valid && bus.mem_req_addr == a && bus.mem_req_type == t &&
          bus.mem_req_source_id == s)
        pulses++;
      tick();
      if (bus.mem_req_valid) stray++;
      bus.mem_req_ready = (r == nrej);
      tick();
      bus.mem_req_ready = 1'b0;
    end
  endtask

  task automatic send_resp(input logic [63:0] a);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_addr  = a;
    tick();
    bus.mem_resp_valid = 1'b0;
  endtask

  task automatic pop_rsp();
    bus.out_rsp_ready = 1'b1;
    tick();
    bus.out_rsp_ready = 1'b0;
  endtask

  task automatic peek_ready(input logic t, input logic [63:0] a, output logic rdy);
    bus.in_req_valid = 1'b0;
    bus.in_req_type  = t;
    bus.in_req_addr  = a;
    #1;
    rdy = bus.in_req_ready;
  endtask

  initial begin
    int          p;
    int          s;
    bit          ok;
    logic        rdy;
    logic [63:0] a;
    logic [31:0] src;

    rv[0] = '{1'b0, 64'h1000, 32'd5,      0, 1, 1};
    rv[1] = '{1'b1, 64'h2000, 32'd7,      1, 2, 1};
    rv[2] = '{1'b0, 64'h3000, 32'd9,      2, 3, 2};
    rv[3] = '{1'b0, 64'h4000, 32'hABCD,   0, 1, 3};
    sv[0] = '{64'h3000, 32'd9,    2};
    sv[1] = '{64'h1000, 32'd5,    1};
    sv[2] = '{64'h4000, 32'hABCD, 0};

    rst_n                = 1'b0;
    bus.in_req_valid     = 1'b0;
    bus.in_req_addr      = '0;
    bus.in_req_type      = 1'b0;
    bus.in_req_source_id = '0;
    bus.mem_init_done    = 1'b0;
    bus.mem_req_ready    = 1'b0;
    bus.mem_resp_valid   = 1'b0;
    bus.mem_resp_addr    = '0;
    bus.out_rsp_ready    = 1'b0;
    repeat (3) tick();

    check("rst_mem_req_valid", bus.mem_req_valid, 0);
    check("rst_out_rsp_valid", bus.out_rsp_valid, 0);
    check("rst_outstanding", bus.outstanding, 0);
    check("rst_err", bus.err_unmatched, 0);
    rst_n = 1'b1;
    tick();
    check("no_init_ready", bus.in_req_ready, 0);
    bus.mem_init_done = 1'b1;
    tick();

    // Single read with exact cycle positions
    bus.in_req_valid     = 1'b1;
    bus.in_req_type      = 1'b0;
    bus.in_req_addr      = 64'h1000;
    bus.in_req_source_id = 32'd5;
    #1;
    check("single_ready_k", bus.in_req_ready, 1);
    tick();
    bus.in_req_valid = 1'b0;
    check("single_pulse_k1", bus.mem_req_valid, 1);
    check("single_addr_k1", bus.mem_req_addr, 64'h1000);
    check("single_src_k1", bus.mem_req_source_id, 5);
    check("single_busy_k1", bus.in_req_ready, 0);
    check("single_outst_k1", bus.outstanding, 1);
    tick();
    check("single_pulse_k2", bus.mem_req_valid, 0);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    bus.in_req_addr   = 64'h9000;
    #1;
    check("single_ready_k3", bus.in_req_ready, 1);
    repeat (7) tick();
    send_resp(64'h1000);
    check("single_rsp_valid_k11", bus.out_rsp_valid, 1);
    check("single_rsp_addr", bus.out_rsp_addr, 64'h1000);
    check("single_rsp_src", bus.out_rsp_source_id, 5);
    check("single_outst_before_pop", bus.outstanding, 1);
    pop_rsp();
    check("single_outst_after_pop", bus.outstanding, 0);
    check("single_rsp_empty", bus.out_rsp_valid, 0);

    // Request table: mixed types and retry counts
    for (int i = 0; i < 4; i++) begin
      send_req(rv[i].t, rv[i].addr, rv[i].src, rv[i].nrej, p, s, ok);
      check($sformatf("vec%0d_accept", i), ok, 1);
      check($sformatf("vec%0d_pulses", i), p, rv[i].exp_pulses);
      check($sformatf("vec%0d_stray", i), s, 0);
      check($sformatf("vec%0d_outst", i), bus.outstanding, rv[i].exp_outst);
    end
    for (int i = 0; i < 3; i++) begin
      send_resp(sv[i].addr);
      check($sformatf("rsp%0d_valid", i), bus.out_rsp_valid, 1);
      check($sformatf("rsp%0d_addr", i), bus.out_rsp_addr, sv[i].addr);
      check($sformatf("rsp%0d_src", i), bus.out_rsp_source_id, sv[i].exp_src);
      pop_rsp();
      check($sformatf("rsp%0d_outst", i), bus.outstanding, sv[i].exp_outst);
    end

    // Full table
    for (int i = 0; i < 8; i++) begin
      send_req(1'b0, 64'h10000 + 64'(i) * 64'h100, 32'(100 + i), 0, p, s, ok);
      check($sformatf("fill%0d_accept", i), ok, 1);
    end
    check("full_outst", bus.outstanding, 8);
    peek_ready(1'b0, 64'h20000, rdy);
    check("full_read_stall", rdy, 0);
    send_req(1'b1, 64'h30000, 32'd300, 0, p, s, ok);
    check("full_write_accept", ok, 1);
    check("full_write_outst", bus.outstanding, 8);
    send_resp(64'h10300);
    check("full_rsp_src", bus.out_rsp_source_id, 103);
    bus.in_req_valid     = 1'b1;
    bus.in_req_type      = 1'b0;
    bus.in_req_addr      = 64'h20000;
    bus.in_req_source_id = 32'd200;
    bus.out_rsp_ready    = 1'b1;
    #1;
    check("free_not_same_cycle", bus.in_req_ready, 0);
    tick();
    bus.out_rsp_ready = 1'b0;
    check("free_next_cycle", bus.in_req_ready, 1);
    check("free_outst", bus.outstanding, 7);
    send_req(1'b0, 64'h20000, 32'd200, 0, p, s, ok);
    check("ninth_accept", ok, 1);
    check("ninth_outst", bus.outstanding, 8);
    for (int i = 0; i < 8; i++) begin
      a   = (i == 3) ? 64'h20000 : 64'h10000 + 64'(i) * 64'h100;
      src = (i == 3) ? 32'd200 : 32'(100 + i);
      send_resp(a);
      check($sformatf("drain%0d_src", i), bus.out_rsp_source_id, src);
      pop_rsp();
    end
    check("drain_outst", bus.outstanding, 0);
    check("drain_err", bus.err_unmatched, 0);

    // Duplicate-address stall
    send_req(1'b0, 64'h40, 32'h40, 0, p, s, ok);
    check("dup_read_accept", ok, 1);
    peek_ready(1'b1, 64'h40, rdy);
    check("dup_write_stall_outst", rdy, 0);
    send_req(1'b1, 64'h80, 32'h80, 0, p, s, ok);
    check("dup_other_write_accept", ok, 1);
    send_resp(64'h40);
    peek_ready(1'b1, 64'h40, rdy);
    check("dup_write_stall_returned", rdy, 0);
    bus.out_rsp_ready = 1'b1;
    #1;
    check("dup_stall_pop_cycle", bus.in_req_ready, 0);
    tick();
    bus.out_rsp_ready = 1'b0;
    check("dup_release", bus.in_req_ready, 1);
    send_req(1'b1, 64'h40, 32'h41, 0, p, s, ok);
    check("dup_write_accept", ok, 1);

    // Out-of-order return with consumer stalled
    send_req(1'b0, 64'h100, 32'd1, 0, p, s, ok);
    send_req(1'b0, 64'h200, 32'd2, 0, p, s, ok);
    check("ooo_outst", bus.outstanding, 2);
    send_resp(64'h200);
    send_resp(64'h100);
    repeat (5) tick();
    check("ooo_first_valid", bus.out_rsp_valid, 1);
    check("ooo_first_src", bus.out_rsp_source_id, 2);
    check("ooo_first_addr", bus.out_rsp_addr, 64'h200);
    pop_rsp();
    check("ooo_second_src", bus.out_rsp_source_id, 1);
    check("ooo_second_addr", bus.out_rsp_addr, 64'h100);
    pop_rsp();
    check("ooo_empty", bus.out_rsp_valid, 0);
    check("ooo_outst_end", bus.outstanding, 0);

    // Unmatched response, then asynchronous reset in WAIT_ACK
    check("pre_unmatched_err", bus.err_unmatched, 0);
    send_resp(64'hDEAD);
    check("unmatched_err", bus.err_unmatched, 1);
    check("unmatched_no_rsp", bus.out_rsp_valid, 0);
    bus.in_req_valid     = 1'b1;
    bus.in_req_type      = 1'b0;
    bus.in_req_addr      = 64'h500;
    bus.in_req_source_id = 32'd55;
    #1;
    tick();
    bus.in_req_valid = 1'b0;
    tick();
    check("wait_outst", bus.outstanding, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_req_valid", bus.mem_req_valid, 0);
    check("async_rst_outst", bus.outstanding, 0);
    check("async_rst_err", bus.err_unmatched, 0);
    check("async_rst_rsp_valid", bus.out_rsp_valid, 0);
    check("async_rst_req_addr", bus.mem_req_addr, 0);
    check("async_rst_req_src", bus.mem_req_source_id, 0);
    tick();
    rst_n = 1'b1;
    tick();
    send_resp(64'h500);
    check("late_rsp_err", bus.err_unmatched, 1);
    check("late_rsp_no_out", bus.out_rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
